display_arbiter: RTL and testbench

Arbiter and scan controller for the shared four-digit seven-segment display on the game board. It takes three display requesters: score, winner and invalid-input. Each supplies a 4-digit segment pattern. The block grants the display to one requester by fixed priority with a minimum hold time, then time-multiplexes the granted pattern onto `ssSel`/`ssDisp`. It replaces the AND-merge of display sources and sits between the game FSM's message generators and the board pins.

---
 rtl/display_arbiter_pkg.sv | 43 ++++
 rtl/digit_scanner.sv | 37 +++
 rtl/display_arbiter.sv | 139 +++++++++++++
 tb/tb_display_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the seven-segment display arbiter.
// The optional winner flashing is enabled with DISPLAY_ARBITER_FLASH_EN.
package display_arbiter_pkg;

    typedef logic [1:0] arbStateT;

    localparam arbStateT ST_IDLE    = 2'd0;
    localparam arbStateT ST_SCORE   = 2'd1;
    localparam arbStateT ST_WINNER  = 2'd2;
    localparam arbStateT ST_INVALID = 2'd3;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // One-hot grant, bit order {invalid, winner, score}.
    localparam logic [2:0] GNT_NONE    = 3'b000;
    localparam logic [2:0] GNT_SCORE   = 3'b001;
    localparam logic [2:0] GNT_WINNER  = 3'b010;
    localparam logic [2:0] GNT_INVALID = 3'b100;

    function automatic logic [3:0] digitSelect(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'b0111;
            2'd1:    return 4'b1011;
            2'd2:    return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [2:0] grantOf(input arbStateT st);
        case (st)
            ST_SCORE:   return GNT_SCORE;
            ST_WINNER:  return GNT_WINNER;
            ST_INVALID: return GNT_INVALID;
            default:    return GNT_NONE;
        endcase
    endfunction

    // A counter for a modulus of 1 still needs one bit to exist.
    function automatic int counterWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_scanner.sv
// Digit prescaler: holds each digit for SCAN_DIV cycles and drives the registered
// active-low digit select alongside the current digit index.
module digit_scanner
    import display_arbiter_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic [1:0] digitIdx,
    output logic [0:3] ssSel
);

    localparam int                SCAN_W    = counterWidth(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [SCAN_W-1:0] scanCnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            scanCnt  <= '0;
            digitIdx <= '0;
            ssSel    <= 4'b1111;
        end else begin
            ssSel <= digitSelect(digitIdx);
            if (scanCnt == SCAN_LAST) begin
                scanCnt  <= '0;
                digitIdx <= digitIdx + 2'd1;
            end else begin
                scanCnt <= scanCnt + SCAN_W'(1);
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Fixed-priority, minimum-hold arbiter for the shared four-digit display plus output mux.
// Define DISPLAY_ARBITER_FLASH_EN to flash the winner message with half-period FLASH_DIV.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 100000000
`ifdef DISPLAY_ARBITER_FLASH_EN
    ,
    parameter int FLASH_DIV   = 25000000
`endif
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_score,
    input  logic        req_winner,
    input  logic        req_invalid,
    input  logic [31:0] seg_score,
    input  logic [31:0] seg_winner,
    input  logic [31:0] seg_invalid,
    output logic [0:3]  ssSel,
    output logic [0:7]  ssDisp,
    output logic [2:0]  gnt,
    output logic        gnt_change
);

    localparam int                HOLD_W    = counterWidth(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    arbStateT          state;
    arbStateT          stateNext;
    arbStateT          bestState;
    logic [HOLD_W-1:0] holdCnt;
    logic              holdDone;
    logic              curReq;
    logic [1:0]        digitIdx;
    logic [31:0]       srcPattern;
    logic [7:0]        digitPattern;
    logic              blankNow;

    digit_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .CLK      (CLK),
        .RESET    (RESET),
        .digitIdx (digitIdx),
        .ssSel    (ssSel)
    );

    assign holdDone = (holdCnt == HOLD_LAST);

    // NOTE: every combinational output gets a default before the case so that no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        bestState = ST_IDLE;
        if (req_invalid)     bestState = ST_INVALID;
        else if (req_winner) bestState = ST_WINNER;
        else if (req_score)  bestState = ST_SCORE;
    end

    always_comb begin
        curReq = 1'b0;
        case (state)
            ST_SCORE:   curReq = req_score;
            ST_WINNER:  curReq = req_winner;
            ST_INVALID: curReq = req_invalid;
            default:    curReq = 1'b0;
        endcase
    end

    // Invalid preempts anything; otherwise a live owner keeps the display until its hold expires.
    always_comb begin
        stateNext = state;
        if (req_invalid && (state != ST_INVALID)) stateNext = ST_INVALID;
        else if (!(curReq && !holdDone))          stateNext = bestState;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            holdCnt    <= '0;
            gnt_change <= 1'b0;
        end else begin
            state      <= stateNext;
            gnt_change <= (stateNext != state);
            if ((stateNext != state) || (state == ST_IDLE)) holdCnt <= '0;
            else if (!holdDone)                             holdCnt <= holdCnt + HOLD_W'(1);
        end
    end

    assign gnt = grantOf(state);

    always_comb begin
        srcPattern = {4{SEG_BLANK}};
        case (state)
            ST_SCORE:   srcPattern = seg_score;
            ST_WINNER:  srcPattern = seg_winner;
            ST_INVALID: srcPattern = seg_invalid;
            default:    srcPattern = {4{SEG_BLANK}};
        endcase
    end

    assign digitPattern = srcPattern[{digitIdx, 3'b000} +: 8];

`ifdef DISPLAY_ARBITER_FLASH_EN
    localparam int                 FLASH_W    = counterWidth(FLASH_DIV);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);

    logic [FLASH_W-1:0] flashCnt;
    logic               flashOff;

    // Phase restarts "on" at every entry into WINNER so the message is visible first.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flashCnt <= '0;
            flashOff <= 1'b0;
        end else if ((state != ST_WINNER) || (stateNext != ST_WINNER)) begin
            flashCnt <= '0;
            flashOff <= 1'b0;
        end else if (flashCnt == FLASH_LAST) begin
            flashCnt <= '0;
            flashOff <= ~flashOff;
        end else begin
            flashCnt <= flashCnt + FLASH_W'(1);
        end
    end

    assign blankNow = flashOff && (state == ST_WINNER);
`else
    assign blankNow = 1'b0;
`endif

    // Registered on the same edge as ssSel so digit select and segments stay coherent.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) ssDisp <= SEG_BLANK;
        else       ssDisp <= blankNow ? SEG_BLANK : digitPattern;
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized + directed bench for display_arbiter against a cycle-level reference model
// written from the arbitration rules (owner, age since grant, edges since reset).
module tb_display_arbiter;

    localparam int SCAN_DIV    = 4;
    localparam int HOLD_CYCLES = 8;
`ifdef DISPLAY_ARBITER_FLASH_EN
    localparam int FLASH_DIV   = 16;
`endif

    logic        CLK;
    logic        RESET;
    logic        req_score;
    logic        req_winner;
    logic        req_invalid;
    logic [31:0] seg_score;
    logic [31:0] seg_winner;
    logic [31:0] seg_invalid;
    logic [0:3]  ssSel;
    logic [0:7]  ssDisp;
    logic [2:0]  gnt;
    logic        gnt_change;

    int errCount   = 0;
    int checkCount = 0;

    // Model: owner 0=idle 1=score 2=winner 3=invalid; age = edges since owner was granted.
    int owner;
    int age;
    int edges;

`ifdef DISPLAY_ARBITER_FLASH_EN
    display_arbiter #(
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_CYCLES (HOLD_CYCLES),
        .FLASH_DIV   (FLASH_DIV)
    ) dut (
`else
    display_arbiter #(
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
`endif
        .CLK         (CLK),
        .RESET       (RESET),
        .req_score   (req_score),
        .req_winner  (req_winner),
        .req_invalid (req_invalid),
        .seg_score   (seg_score),
        .seg_winner  (seg_winner),
        .seg_invalid (seg_invalid),
        .ssSel       (ssSel),
        .ssDisp      (ssDisp),
        .gnt         (gnt),
        .gnt_change  (gnt_change)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, actual, expected);
        end
    endtask

    function automatic logic reqOf(input int o);
        case (o)
            1:       return req_score;
            2:       return req_winner;
            3:       return req_invalid;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] segOf(input int o);
        case (o)
            1:       return seg_score;
            2:       return seg_winner;
            3:       return seg_invalid;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic int bestOwner();
        if (req_invalid) return 3;
        if (req_winner)  return 2;
        if (req_score)   return 1;
        return 0;
    endfunction

    task automatic resetModel();
        owner = 0;
        age   = 0;
        edges = 0;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, ".ssSel"},  32'(ssSel),      32'hF);
        check({tag, ".ssDisp"}, 32'(ssDisp),     32'hFF);
        check({tag, ".gnt"},    32'(gnt),        32'h0);
        check({tag, ".chg"},    32'(gnt_change), 32'h0);
    endtask

    // One clock edge: predict from pre-edge inputs and model state, then compare.
    task automatic step();
        int          idx;
        int          nextOwner;
        logic [31:0] src;
        logic [7:0]  expDisp;
        logic [3:0]  expSel;
        logic        expChange;
        logic [2:0]  expGnt;
        idx     = (edges / SCAN_DIV) % 4;
        src     = segOf(owner);
        expDisp = src[8*idx +: 8];
`ifdef DISPLAY_ARBITER_FLASH_EN
        if (owner == 2 && ((age / FLASH_DIV) % 2 == 1)) expDisp = 8'hFF;
`endif
        expSel = ~(4'b1000 >> idx);
        if (req_invalid && owner != 3)
            nextOwner = 3;
        else if (owner != 0 && reqOf(owner) && age < HOLD_CYCLES - 1)
            nextOwner = owner;
        else
            nextOwner = bestOwner();
        @(posedge CLK);
        #1;
        expChange = (nextOwner != owner);
        age   = expChange ? 0 : age + 1;
        owner = nextOwner;
        edges++;
        expGnt = (owner == 0) ? 3'b000 : 3'(1 << (owner - 1));
        check("gnt",        32'(gnt),        32'(expGnt));
        check("gnt_change", 32'(gnt_change), 32'(expChange));
        check("ssSel",      32'(ssSel),      32'(expSel));
        check("ssDisp",     32'(ssDisp),     32'(expDisp));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        RESET       = 1'b1;
        req_score   = 1'b0;
        req_winner  = 1'b0;
        req_invalid = 1'b0;
        seg_score   = 32'hC0F9A4B0;
        seg_winner  = 32'h8892C7C1;
        seg_invalid = 32'h86AFAF86;
        resetModel();

        #2;
        checkResetValues("rst0");
        repeat (3) @(posedge CLK);
        #1;
        checkResetValues("rstHeld");
        RESET = 1'b0;

        // Idle scan: blank segments, digit select rotating every SCAN_DIV cycles.
        steps(20);

        // Score granted, winner requested at hold count 2, waits for hold expiry.
        req_score = 1'b1;
        steps(3);
        req_winner = 1'b1;
        steps(12);

        // Invalid preempts winner with no hold wait, then hands back.
        req_invalid = 1'b1;
        steps(2);
        req_invalid = 1'b0;
        steps(3);

        // Everything drops, then score dropped mid-hold.
        req_winner = 1'b0;
        req_score  = 1'b0;
        steps(3);
        req_score = 1'b1;
        steps(3);
        req_score = 1'b0;
        steps(3);

        // Winner held long enough to span several flash half-periods.
        req_winner = 1'b1;
        steps(64);
        seg_winner = 32'h12345678;
        steps(6);

        // Asynchronous reset mid-operation, away from the clock edge.
        #3;
        RESET = 1'b1;
        #1;
        checkResetValues("asyncRst");
        @(posedge CLK);
        #1;
        checkResetValues("asyncRstHeld");
        RESET = 1'b0;
        resetModel();
        steps(6);

        // Randomized requests with slow toggling so holds and preemption both occur.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0)  req_score   = ~req_score;
            if ($urandom_range(0, 8) == 0)  req_winner  = ~req_winner;
            if ($urandom_range(0, 14) == 0) req_invalid = ~req_invalid;
            if ($urandom_range(0, 9) == 0)  seg_score   = $urandom;
            if ($urandom_range(0, 9) == 0)  seg_winner  = $urandom;
            if ($urandom_range(0, 9) == 0)  seg_invalid = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
